multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit: replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It drives the shared-ALU/shared-memory datapath and waits on a memory ready handshake with a bounded timeout. Supported instructions: R-type, lw, sw, beq and j, plus optional addi. It sits between the instruction register opcode field and the datapath mux/enable controls.

## Interface
- OPCODE_W, 6: opcode field width.
- WAIT_CNT_W, 4: memory-wait counter width; timeout after 2^WAIT_CNT_W-1 unready wait cycles (default 15).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  IR opcode field; sampled in DECODE.
- mem_ready  in  1  memory completed the current read/write this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- mem_error  out  1  one-cycle pulse on memory timeout.
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- state  out  4  current state code (debug).

## Operation
- States (codes 0-11): FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
- Outputs not listed for a state are 0; no output is ever X.
- FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready=1, otherwise waits.
- DECODE: alu_src_b=11. Next state by opcode: 000000 R_EXEC; 100011/101011 MEM_ADDR; 000100 BRANCH; 000010 JUMP; 001000 ADDI_EXEC (macro only). Any other opcode: illegal_op=1, next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next MEM_READ for lw, MEM_WRITE for sw (opcode held stable by IR).
- MEM_READ: mem_read=1, i_or_d=1; waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1, then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; when mem_ready=1: instr_done=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_op=10. R_WB: reg_dst=1, reg_write=1, instr_done=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
- JUMP: pc_write=1, pc_source=10, instr_done=1.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10. ADDI_WB: reg_write=1, instr_done=1.
- Wait states (FETCH, MEM_READ, MEM_WRITE): the counter clears on state entry and increments each cycle with mem_ready=0. When the counter equals max and mem_ready=0, the block pulses mem_error, suppresses all writes, and goes to FETCH. If mem_ready=1 arrives on the same cycle as the timeout, ready wins and no error is raised.

## Timing
- Reset: every output is 0 while reset=1. The first cycle after release is FETCH with the counter at 0.
- Reset asserted mid-instruction aborts it: no write strobe is issued in that cycle.
- Latency with zero-wait memory (mem_ready=1 on first cycle), cycles FETCH to instr_done inclusive: beq 3, j 3, R-type 4, sw 4, addi 4, lw 5.
- Each unready wait cycle adds one cycle. ir_write, pc_write in FETCH and mem_write completion are Mealy on mem_ready; all other outputs are Moore.

## Configuration
- MULTICYCLE_CONTROL_ADDI_EN defined: opcode 001000 runs ADDI_EXEC, then ADDI_WB.
- Not defined: ADDI states are absent, and 001000 is illegal (illegal_op pulse, then FETCH).

## Structure
- Package multicycle_control_pkg holds:
  - state code constants;
  - opcode constants (R, LW, SW, BEQ, J, ADDI);
  - alu_op, alu_src_b and pc_source encodings.
- Sub-module mc_wait_timer: counter with clear and enable inputs and a timeout output, width WAIT_CNT_W.

## Test plan
- Reset held 3 cycles, then released -> all outputs 0 during reset; state=0 and mem_read=1 on the first cycle after release.
- Zero-wait R-type (opcode 000000) -> state sequence 0,1,6,7; reg_write and instr_done pulse on cycle 4.
- lw with mem_ready low for 3 cycles in MEM_READ -> instr_done on cycle 8; mem_to_reg=1 only in MEM_WB.
- sw with mem_ready never asserted -> mem_error pulses after 15 wait cycles; mem_write drops; state returns to FETCH.
- mem_ready rises on exactly the 15th wait cycle -> no mem_error; the transaction completes.
- Opcode 001000 -> with macro, 4-cycle addi with reg_write=1, reg_dst=0; without macro, illegal_op pulse in DECODE and return to FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// opcodes, and the datapath mux select values.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // States that stall on the memory handshake and run the wait timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/memory handshake inputs and datapath control outputs of the
// multi-cycle control unit, bundled as one interface.
interface multicycle_control_if #(
  parameter int OPCODE_W = 6
);

  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       mem_error;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, mem_error, illegal_op, state
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, mem_error, illegal_op, state
  );

endinterface

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter: counts unready cycles and flags when it sits at
// its maximum value, at which point the next unready cycle is a timeout.
module mc_wait_timer #(
  parameter int WAIT_CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (count_q == '1);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM sequencing fetch/decode/execute/memory/writeback.
// Define MULTICYCLE_CONTROL_ADDI_EN to add the addi instruction (opcode 001000).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int WAIT_CNT_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  state_e state_q;
  state_e state_d;

  logic       timer_at_max;
  logic       timer_clr;
  logic       timer_en;
  logic       wait_tmo;
  logic       in_wait;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       mem_error;
  logic       illegal_op;

  assign in_wait  = is_wait_state(state_q);
  assign timer_en = in_wait && !bus.mem_ready;
  // A ready on the timeout cycle still wins: timeout requires mem_ready low.
  assign wait_tmo = in_wait && !bus.mem_ready && timer_at_max;
  // The timer restarts on every state change and on a timeout back into FETCH.
  assign timer_clr = wait_tmo || (state_d != state_q);

  mc_wait_timer #(
    .WAIT_CNT_W(WAIT_CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .timeout (timer_at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    instr_done    = 1'b0;
    mem_error     = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_tmo) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        case (bus.opcode)
          OPCODE_W'(OP_R):                   state_d = S_R_EXEC;
          OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): state_d = S_MEM_ADDR;
          OPCODE_W'(OP_BEQ):                 state_d = S_BRANCH;
          OPCODE_W'(OP_J):                   state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          OPCODE_W'(OP_ADDI):                state_d = S_ADDI_EXEC;
`else
          OPCODE_W'(OP_ADDI): begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_tmo) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        i_or_d    = 1'b1;
        mem_write = !wait_tmo;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (wait_tmo) begin
          mem_error = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset blanks every control so an aborted instruction issues no strobe.
    if (reset) begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      mem_error     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.instr_done    = instr_done;
  assign bus.mem_error     = mem_error;
  assign bus.illegal_op    = illegal_op;
  assign bus.state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: random instruction stream with
// random memory wait lengths, checked cycle by cycle against a plan model.
module tb_multicycle_control;

  localparam int OPCODE_W   = 6;
  localparam int WAIT_CNT_W = 4;
  localparam int MAX_WAIT   = (1 << WAIT_CNT_W) - 1;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       mem_error;
    logic       illegal_op;
  } obs_t;

  typedef struct packed {
    logic rdy;
    obs_t exp;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  step_t plan[$];

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(OPCODE_W)) bus ();

  multicycle_control #(
    .OPCODE_W  (OPCODE_W),
    .WAIT_CNT_W(WAIT_CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Moore outputs of each state, written straight from the state descriptions.
  function automatic obs_t state_outputs(input int code);
    obs_t o;
    o = '0;
    o.state = 4'(code);
    case (code)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; end
      1:  begin o.alu_src_b = 2'b11; end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                o.pc_source = 2'b01; o.instr_done = 1; end
      9:  begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      11: begin o.reg_write = 1; o.instr_done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    bit legal;
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    legal = legal || (op == 6'b001000);
`endif
    return legal;
  endfunction

  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'b000100, 6'b000010:           return 3;
      6'b000000, 6'b101011, 6'b001000: return 4;
      6'b100011:                      return 5;
      default:                        return 0;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state         = bus.state;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_dst       = bus.reg_dst;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.pc_source     = bus.pc_source;
    o.instr_done    = bus.instr_done;
    o.mem_error     = bus.mem_error;
    o.illegal_op    = bus.illegal_op;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic rst);
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    reset         = rst;
    #1;
  endtask

  task automatic push_step(input logic rdy, input obs_t e);
    step_t s;
    s.rdy = rdy;
    s.exp = e;
    plan.push_back(s);
  endtask

  // d unready cycles then ready; d beyond MAX_WAIT means memory never answers.
  task automatic wait_phase(input int code, input int d, output bit ok);
    obs_t e;
    int   unready;
    unready = (d > MAX_WAIT) ? MAX_WAIT : d;
    for (int i = 0; i < unready; i++) push_step(1'b0, state_outputs(code));
    e = state_outputs(code);
    if (d > MAX_WAIT) begin
      e.mem_error = 1'b1;
      e.mem_write = 1'b0;
      push_step(1'b0, e);
      ok = 1'b0;
    end else begin
      if (code == 0) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      if (code == 5) e.instr_done = 1'b1;
      push_step(1'b1, e);
      ok = 1'b1;
    end
  endtask

  task automatic build_plan(input logic [5:0] op, input int d_fetch, input int d_mem,
                            output int exp_lat);
    obs_t e;
    bit   ok;
    bit   completes;
    bit   is_mem;
    plan.delete();
    completes = 1'b0;
    is_mem = (op == 6'b100011) || (op == 6'b101011);
    wait_phase(0, d_fetch, ok);
    if (ok) begin
      e = state_outputs(1);
      if (!is_legal(op)) e.illegal_op = 1'b1;
      push_step(1'($urandom_range(0, 1)), e);
      if (is_legal(op)) begin
        completes = 1'b1;
        case (op)
          6'b000000: begin
            push_step(1'($urandom_range(0, 1)), state_outputs(6));
            push_step(1'($urandom_range(0, 1)), state_outputs(7));
          end
          6'b100011: begin
            push_step(1'($urandom_range(0, 1)), state_outputs(2));
            wait_phase(3, d_mem, ok);
            if (ok) push_step(1'($urandom_range(0, 1)), state_outputs(4));
            completes = ok;
          end
          6'b101011: begin
            push_step(1'($urandom_range(0, 1)), state_outputs(2));
            wait_phase(5, d_mem, ok);
            completes = ok;
          end
          6'b000100: push_step(1'($urandom_range(0, 1)), state_outputs(8));
          6'b000010: push_step(1'($urandom_range(0, 1)), state_outputs(9));
          default: begin
            push_step(1'($urandom_range(0, 1)), state_outputs(10));
            push_step(1'($urandom_range(0, 1)), state_outputs(11));
          end
        endcase
      end
    end
    exp_lat = completes ? base_latency(op) + d_fetch + (is_mem ? d_mem : 0) : 0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int d_fetch, input int d_mem);
    int   exp_lat;
    int   done_at;
    obs_t o;
    build_plan(op, d_fetch, d_mem, exp_lat);
    done_at = 0;
    for (int i = 0; i < plan.size(); i++) begin
      applyStimulus(op, plan[i].rdy, 1'b0);
      o = sample();
      checkOutput($sformatf("op=%b cycle=%0d", op, i + 1), 32'(o), 32'(plan[i].exp));
      if (done_at == 0 && o.instr_done === 1'b1) done_at = i + 1;
    end
    checkOutput($sformatf("latency op=%b", op), 32'(done_at), 32'(exp_lat));
  endtask

  // Run the first n cycles of an instruction, then assert reset with memory ready.
  task automatic run_abort(input logic [5:0] op, input int n);
    int   exp_lat;
    obs_t o;
    build_plan(op, 0, 0, exp_lat);
    for (int i = 0; i < n && i < plan.size(); i++) begin
      applyStimulus(op, plan[i].rdy, 1'b0);
      o = sample();
      checkOutput($sformatf("abort op=%b cycle=%0d", op, i + 1), 32'(o), 32'(plan[i].exp));
    end
    applyStimulus(op, 1'b1, 1'b1);
    checkOutput("reset mid-instruction", 32'(sample()), 32'd0);
  endtask

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return r % 4;
    if (r == 16) return MAX_WAIT - 1;
    if (r == 17) return MAX_WAIT;
    return MAX_WAIT + 1;
  endfunction

  function automatic logic [5:0] rand_opcode();
    logic [5:0] ops [7];
    ops[0] = 6'b000000;
    ops[1] = 6'b100011;
    ops[2] = 6'b101011;
    ops[3] = 6'b000100;
    ops[4] = 6'b000010;
    ops[5] = 6'b001000;
    ops[6] = 6'b110000 | 6'($urandom_range(0, 15));
    return ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    reset         = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b1);
      checkOutput($sformatf("reset cycle %0d", i + 1), 32'(sample()), 32'd0);
    end

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b101011, 0, MAX_WAIT + 1);
    run_instr(6'b101011, 0, MAX_WAIT - 1);
    run_instr(6'b101011, 0, MAX_WAIT);
    run_instr(6'b100011, 1, MAX_WAIT);
    run_instr(6'b000000, MAX_WAIT + 1, 0);
    run_instr(6'b000100, 2, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_abort(6'b101011, 3);
    run_instr(6'b100011, 0, 0);

    for (int n = 0; n < 60; n++) begin
      run_instr(rand_opcode(), rand_delay(), rand_delay());
    end

    run_abort(6'b000000, 3);
    for (int n = 0; n < 10; n++) begin
      run_instr(rand_opcode(), rand_delay(), rand_delay());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
